// File: rtl/tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings and default opcodes.
package tap_pkg;

   typedef enum logic [3:0] {
      TLR      = 4'hF,
      RTI      = 4'hC,
      SEL_DR   = 4'h7,
      CAP_DR   = 4'h6,
      SH_DR    = 4'h2,
      EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3,
      EX2_DR   = 4'h0,
      UPD_DR   = 4'h5,
      SEL_IR   = 4'h4,
      CAP_IR   = 4'hE,
      SH_IR    = 4'hA,
      EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB,
      EX2_IR   = 4'h8,
      UPD_IR   = 4'hD
   } tap_state_e;

   localparam int         IR_W_DEF      = 4;
   localparam logic [3:0] OP_EXTEST_DEF = 4'b0000;
   localparam logic [3:0] OP_SAMPLE_DEF = 4'b0001;
   localparam logic [3:0] OP_BYPASS_DEF = 4'b1111;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP FSM: TMS sampled on each TCK rising edge, state register is the only output.
//
//  state    | meaning
//  TLR      | test-logic-reset, IR forced to BYPASS
//  RTI      | run-test/idle
//  SEL_DR   | select DR scan
//  CAP_DR   | capture into selected data register
//  SH_DR    | shift data register, one bit per cycle
//  EX1_DR   | exit1 DR
//  PAUSE_DR | pause DR, all registers hold
//  EX2_DR   | exit2 DR, may resume shifting
//  UPD_DR   | update data register
//  SEL_IR .. UPD_IR | instruction-register mirror of the DR side
module tap_fsm (
   input  logic       TCK,
   input  logic       Reset,
   input  logic       TMS,
   output logic [3:0] State
);
   import tap_pkg::*;

   tap_state_e state_q, state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         TLR:      state_d = TMS ? TLR    : RTI;
         RTI:      state_d = TMS ? SEL_DR : RTI;
         SEL_DR:   state_d = TMS ? SEL_IR : CAP_DR;
         CAP_DR:   state_d = TMS ? EX1_DR : SH_DR;
         SH_DR:    state_d = TMS ? EX1_DR : SH_DR;
         EX1_DR:   state_d = TMS ? UPD_DR : PAUSE_DR;
         PAUSE_DR: state_d = TMS ? EX2_DR : PAUSE_DR;
         EX2_DR:   state_d = TMS ? UPD_DR : SH_DR;
         UPD_DR:   state_d = TMS ? SEL_DR : RTI;
         SEL_IR:   state_d = TMS ? TLR    : CAP_IR;
         CAP_IR:   state_d = TMS ? EX1_IR : SH_IR;
         SH_IR:    state_d = TMS ? EX1_IR : SH_IR;
         EX1_IR:   state_d = TMS ? UPD_IR : PAUSE_IR;
         PAUSE_IR: state_d = TMS ? EX2_IR : PAUSE_IR;
         EX2_IR:   state_d = TMS ? UPD_IR : SH_IR;
         UPD_IR:   state_d = TMS ? SEL_DR : RTI;
         default:  state_d = TLR;
      endcase
   end

   always_ff @(posedge TCK) begin
      if (Reset) state_q <= TLR;
      else       state_q <= state_d;
   end

   assign State = state_q;

endmodule

// File: rtl/tap_controller.sv
// TAP controller: FSM, instruction register, bypass bit and boundary-chain control decode.
// Chain strobes are Moore decodes of the state register so TMS never reaches them combinationally.
module tap_controller
   import tap_pkg::*;
#(
   parameter int              IR_W      = IR_W_DEF,
   parameter logic [IR_W-1:0] OP_EXTEST = IR_W'(OP_EXTEST_DEF),
   parameter logic [IR_W-1:0] OP_SAMPLE = IR_W'(OP_SAMPLE_DEF),
   parameter logic [IR_W-1:0] OP_BYPASS = '1
) (
   input  logic            TCK,
   input  logic            Reset,
   input  logic            TMS,
   input  logic            TDI,
   input  logic            ChainSO,
   output logic            TDO,
   output logic            TDO_en,
   output logic            SI,
   output logic            ShiftDR,
   output logic            ClockDR,
   output logic            UpdateDR,
   output logic            Mode,
   output logic [IR_W-1:0] IR_out,
   output logic [3:0]      State
);

   logic [3:0]      state;
   logic [IR_W-1:0] ir_q, ir_d;
   logic [IR_W-1:0] irsh_q, irsh_d;
   logic            byp_q, byp_d;
   logic            sel_bsr;

   tap_fsm u_fsm (
      .TCK   (TCK),
      .Reset (Reset),
      .TMS   (TMS),
      .State (state)
   );

   assign sel_bsr = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);

   // Register actions happen on the edge that leaves the named state.
   always_comb begin
      ir_d   = ir_q;
      irsh_d = irsh_q;
      byp_d  = byp_q;
      case (state)
         CAP_IR:  irsh_d = IR_W'(2'b01);
         SH_IR:   irsh_d = {TDI, irsh_q[IR_W-1:1]};
         UPD_IR:  ir_d   = irsh_q;
         CAP_DR:  byp_d  = 1'b0;
         SH_DR:   if (!sel_bsr) byp_d = TDI;
         default: ;
      endcase
      // TLR is only entered from SEL_IR (or held), so this covers every TMS route into it.
      if ((state == TLR) || ((state == SEL_IR) && TMS)) ir_d = OP_BYPASS;
   end

   always_ff @(posedge TCK) begin
      if (Reset) begin
         ir_q   <= OP_BYPASS;
         irsh_q <= '0;
         byp_q  <= 1'b0;
      end else begin
         ir_q   <= ir_d;
         irsh_q <= irsh_d;
         byp_q  <= byp_d;
      end
   end

   always_comb begin
      TDO = 1'b0;
      if (state == SH_IR)      TDO = irsh_q[0];
      else if (state == SH_DR) TDO = sel_bsr ? ChainSO : byp_q;
   end

   assign TDO_en   = (state == SH_IR) || (state == SH_DR);
   assign SI       = TDI;
   assign ShiftDR  = (state == SH_DR);
   assign ClockDR  = sel_bsr && ((state == CAP_DR) || (state == SH_DR));
   assign UpdateDR = sel_bsr && (state == UPD_DR);
   assign Mode     = (ir_q == OP_EXTEST);
   assign IR_out   = ir_q;
   assign State    = state;

endmodule
